skid_buffer_reg: RTL and testbench

- Parametrised, fully registered 2-entry skid buffer. It is the successor of the 8-bit skid stage.
- Both directions are registered: e_valid_o/e_data_o come from a main register, and i_ready_o comes from skid-occupancy state. This breaks timing on valid, data and ready paths.
- Adds an occupancy output, a synchronous flush, and optional stall statistics.
- Sits between pipeline stages on any valid/ready stream.

---
 rtl/skid_pkg.sv | 20 ++
 rtl/skid_sat_cnt.sv | 33 +++
 rtl/skid_buffer_reg.sv | 134 +++++++++++++
 tb/tb_skid_buffer_reg.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/skid_pkg.sv
// -----------------------------------------------------------------------------
// skid_pkg
//   Shared constants for the registered skid buffer.
//   ST_W     : width of the occupancy/state code
//   S_EMPTY  : no beat held
//   S_BUSY   : one beat held in the main register
//   S_FULL   : main and skid registers both hold a beat
// The state code is also the occupancy count exported on occ_o.
// -----------------------------------------------------------------------------
package skid_pkg;

    localparam int ST_W = 2;

    typedef logic [ST_W-1:0] skid_state_t;

    localparam skid_state_t S_EMPTY = 2'd0;
    localparam skid_state_t S_BUSY  = 2'd1;
    localparam skid_state_t S_FULL  = 2'd2;

endpackage

// File: rtl/skid_sat_cnt.sv
// -----------------------------------------------------------------------------
// skid_sat_cnt
//   Saturating up-counter: counts cycles with inc_i high, sticks at all-ones.
//   Parameters:
//     W      : counter width
//   Ports:
//     clk    : rising-edge clock
//     reset  : synchronous active-low reset, clears the count
//     inc_i  : increment request for this cycle
//     cnt_o  : current count
// -----------------------------------------------------------------------------
module skid_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/skid_buffer_reg.sv
// -----------------------------------------------------------------------------
// skid_buffer_reg
//   Fully registered 2-entry skid buffer for a valid/ready stream. Downstream
//   valid/data come straight from the main register and upstream ready comes
//   from the skid occupancy, so no combinational path crosses the stage.
//
//   Handshake: a beat moves across an interface on a rising clk edge where
//   both valid and ready are 1. A source holding valid=1 keeps valid and data
//   stable until that edge; ready may change freely. Here
//     in_hs  = i_valid_i & i_ready_o
//     out_hs = e_valid_o & e_ready_i
//
//   Parameters:
//     DATA_W      : payload width
//     CNT_W       : stall counter width (statistics build only)
//   Ports:
//     clk         : rising-edge clock
//     reset       : synchronous active-low reset
//     flush_i     : synchronous flush, drops every held beat
//     i_valid_i   : upstream valid
//     i_data_i    : upstream payload
//     i_ready_o   : upstream ready
//     e_ready_i   : downstream ready
//     e_valid_o   : downstream valid (registered)
//     e_data_o    : downstream payload (registered)
//     occ_o       : beats held (0..2), equal to the internal state code
//     stall_cnt_o : cycles with e_valid_o=1 and e_ready_i=0, saturating;
//                   present only when SKID_STATS_EN is defined
//
//   Build option: define SKID_STATS_EN to add the stall counter and port.
// -----------------------------------------------------------------------------
module skid_buffer_reg
    import skid_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush_i,
    input  logic              i_valid_i,
    input  logic [DATA_W-1:0] i_data_i,
    output logic              i_ready_o,
    input  logic              e_ready_i,
    output logic              e_valid_o,
    output logic [DATA_W-1:0] e_data_o,
    output logic [1:0]        occ_o
`ifdef SKID_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt_o
`endif
);

    skid_state_t       state_q;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              main_v;
    logic              skid_v;
    logic              in_hs;
    logic              out_hs;

    assign main_v = (state_q == S_BUSY) || (state_q == S_FULL);
    assign skid_v = (state_q == S_FULL);

    // Outputs are forced to their idle values while reset is held low, so
    // they are clean even before the first reset edge has cleared the state.
    assign i_ready_o = reset & ~skid_v;
    assign e_valid_o = reset & main_v;
    assign e_data_o  = reset ? main_q : '0;
    assign occ_o     = reset ? state_q : '0;

    assign in_hs  = i_valid_i & i_ready_o;
    assign out_hs = e_valid_o & e_ready_i;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else if (flush_i) begin
            // Data registers keep their contents; only occupancy is dropped.
            state_q <= S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (in_hs) begin
                        main_q  <= i_data_i;
                        state_q <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (in_hs && out_hs) begin
                        main_q <= i_data_i;
                    end else if (in_hs) begin
                        // Downstream stalled: park the new beat behind main.
                        skid_q  <= i_data_i;
                        state_q <= S_FULL;
                    end else if (out_hs) begin
                        state_q <= S_EMPTY;
                    end
                end
                S_FULL: begin
                    // i_ready_o is low here, so only the drain can happen.
                    if (out_hs) begin
                        main_q  <= skid_q;
                        state_q <= S_BUSY;
                    end
                end
                default: state_q <= S_EMPTY;
            endcase
        end
    end

`ifdef SKID_STATS_EN
    logic [CNT_W-1:0] stall_cnt;

    skid_sat_cnt #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc_i (e_valid_o & ~e_ready_i),
        .cnt_o (stall_cnt)
    );

    assign stall_cnt_o = reset ? stall_cnt : '0;
`else
    // CNT_W only sizes the statistics counter; this empty block keeps the
    // parameter referenced in the plain build.
    if (CNT_W > 0) begin : g_no_stats
    end
`endif

endmodule

// File: tb/tb_skid_buffer_reg.sv
// -----------------------------------------------------------------------------
// tb_skid_buffer_reg
//   Directed bench for skid_buffer_reg (DATA_W=8, CNT_W=4). Inputs change
//   1 time unit after a rising edge and outputs are checked there too.
//   The stall counter section runs only when SKID_STATS_EN is defined.
// -----------------------------------------------------------------------------
module tb_skid_buffer_reg;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              reset;
    logic              flush_i;
    logic              i_valid_i;
    logic [DATA_W-1:0] i_data_i;
    logic              i_ready_o;
    logic              e_ready_i;
    logic              e_valid_o;
    logic [DATA_W-1:0] e_data_o;
    logic [1:0]        occ_o;
`ifdef SKID_STATS_EN
    logic [CNT_W-1:0]  stall_cnt_o;
`endif

    int checks;
    int failures;

    skid_buffer_reg #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (flush_i),
        .i_valid_i   (i_valid_i),
        .i_data_i    (i_data_i),
        .i_ready_o   (i_ready_o),
        .e_ready_i   (e_ready_i),
        .e_valid_o   (e_valid_o),
        .e_data_o    (e_data_o),
        .occ_o       (occ_o)
`ifdef SKID_STATS_EN
        ,
        .stall_cnt_o (stall_cnt_o)
`endif
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle away from it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b0;
        flush_i   = 1'b0;
        i_valid_i = 1'b1;
        i_data_i  = 8'hA5;
        e_ready_i = 1'b0;
        #1;

        // ---- Reset held for 3 cycles with upstream pushing 0xA5 ----
        check("rst_t0_ready", i_ready_o, 0);
        check("rst_t0_valid", e_valid_o, 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("rst_ready", i_ready_o, 0);
            check("rst_valid", e_valid_o, 0);
            check("rst_occ", occ_o, 0);
            check("rst_data", e_data_o, 0);
        end
        reset     = 1'b1;
        i_valid_i = 1'b0;
        #1;
        check("rel_ready", i_ready_o, 1);
        check("rel_valid", e_valid_o, 0);
        check("rel_occ", occ_o, 0);

        // ---- Streaming 0x01..0x10 with e_ready_i=1 ----
        e_ready_i = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            i_valid_i = 1'b1;
            i_data_i  = 8'(k);
            #1;
            check("str_ready", i_ready_o, 1);
            cyc();
            check("str_valid", e_valid_o, 1);
            check("str_data", e_data_o, k);
            check("str_occ", occ_o, 1);
        end
        i_valid_i = 1'b0;
        cyc();
        check("str_drain_valid", e_valid_o, 0);
        check("str_drain_occ", occ_o, 0);

        // ---- Backpressure: 0x11, 0x22 with e_ready_i=0 ----
        e_ready_i = 1'b0;
        i_valid_i = 1'b1;
        i_data_i  = 8'h11;
        cyc();
        check("bp1_occ", occ_o, 1);
        check("bp1_data", e_data_o, 8'h11);
        check("bp1_ready", i_ready_o, 1);
        i_data_i = 8'h22;
        cyc();
        check("bp2_occ", occ_o, 2);
        check("bp2_ready", i_ready_o, 0);
        check("bp2_valid", e_valid_o, 1);
        check("bp2_data", e_data_o, 8'h11);
        i_valid_i = 1'b0;
        cyc();
        check("bp_hold_occ", occ_o, 2);
        check("bp_hold_data", e_data_o, 8'h11);
        e_ready_i = 1'b1;
        cyc();
        check("bp_out2_data", e_data_o, 8'h22);
        check("bp_out2_valid", e_valid_o, 1);
        check("bp_out2_occ", occ_o, 1);
        check("bp_out2_ready", i_ready_o, 1);
        cyc();
        check("bp_end_valid", e_valid_o, 0);
        check("bp_end_occ", occ_o, 0);

        // ---- Flush while FULL (0x33, 0x44) ----
        e_ready_i = 1'b0;
        i_valid_i = 1'b1;
        i_data_i  = 8'h33;
        cyc();
        i_data_i = 8'h44;
        cyc();
        check("fl_full_occ", occ_o, 2);
        flush_i  = 1'b1;
        i_data_i = 8'h66;
        cyc();
        flush_i   = 1'b0;
        i_valid_i = 1'b0;
        check("fl_occ", occ_o, 0);
        check("fl_valid", e_valid_o, 0);
        check("fl_ready", i_ready_o, 1);
        e_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("fl_no_emit", e_valid_o, 0);
        end

        // ---- Flush in BUSY: out_hs completes, same-cycle in_hs discarded ----
        e_ready_i = 1'b0;
        i_valid_i = 1'b1;
        i_data_i  = 8'h77;
        cyc();
        check("flb_data", e_data_o, 8'h77);
        e_ready_i = 1'b1;
        i_data_i  = 8'h78;
        flush_i   = 1'b1;
        cyc();
        flush_i   = 1'b0;
        i_valid_i = 1'b0;
        check("flb_occ", occ_o, 0);
        check("flb_valid", e_valid_o, 0);
        cyc();
        check("flb_no_emit", e_valid_o, 0);

        // ---- Reset mid-operation while BUSY with 0x55 ----
        e_ready_i = 1'b0;
        i_valid_i = 1'b1;
        i_data_i  = 8'h55;
        cyc();
        check("mr_busy_data", e_data_o, 8'h55);
        i_valid_i = 1'b0;
        reset     = 1'b0;
        #1;
        check("mr_low_valid", e_valid_o, 0);
        check("mr_low_ready", i_ready_o, 0);
        cyc();
        reset = 1'b1;
        #1;
        check("mr_rel_valid", e_valid_o, 0);
        check("mr_rel_occ", occ_o, 0);
        check("mr_rel_ready", i_ready_o, 1);
        check("mr_rel_data", e_data_o, 0);
        e_ready_i = 1'b1;
        cyc();
        check("mr_lost", e_valid_o, 0);
        i_valid_i = 1'b1;
        i_data_i  = 8'h5A;
        cyc();
        check("mr_resume_valid", e_valid_o, 1);
        check("mr_resume_data", e_data_o, 8'h5A);
        i_valid_i = 1'b0;
        cyc();
        check("mr_resume_drain", e_valid_o, 0);

`ifdef SKID_STATS_EN
        // ---- Stall counter: saturation, flush immunity, reset clear ----
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        #1;
        check("st_clear", stall_cnt_o, 0);
        e_ready_i = 1'b0;
        i_valid_i = 1'b1;
        i_data_i  = 8'h88;
        cyc();
        i_valid_i = 1'b0;
        check("st_load", stall_cnt_o, 0);
        for (int i = 0; i < 5; i++) cyc();
        check("st_five", stall_cnt_o, 5);
        for (int i = 0; i < 15; i++) cyc();
        check("st_sat", stall_cnt_o, 15);
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        check("st_flush_keep", stall_cnt_o, 15);
        check("st_flush_occ", occ_o, 0);
        cyc();
        check("st_idle_keep", stall_cnt_o, 15);
        reset = 1'b0;
        #1;
        check("st_rst_low", stall_cnt_o, 0);
        cyc();
        reset = 1'b1;
        #1;
        check("st_rst_clear", stall_cnt_o, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
